// File: rtl/mux_seq_pkg.sv
// Shared widths, FSM state encoding and output beat payload for the mux4 round-robin sequencer.
package mux_seq_pkg;

    localparam int unsigned N_CH = 4;
    localparam int unsigned CH_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            data;
    } beat_t;

endpackage

// File: rtl/mux4_rr_sequencer_if.sv
// Request/mux/handshake bundle between the sequencer, the mux_4x1 and the downstream consumer.
interface mux4_rr_sequencer_if;
    import mux_seq_pkg::*;

    logic [N_CH-1:0] req;
    logic            mux_y;
    logic            out_ready;
    logic            s0;
    logic            s1;
    logic [N_CH-1:0] gnt;
    logic            out_valid;
    logic            out_data;
    logic [CH_W-1:0] out_ch;
    logic            err;

    modport master (
        input  req, mux_y, out_ready,
        output s0, s1, gnt, out_valid, out_data, out_ch, err
    );

    modport slave (
        output req, mux_y, out_ready,
        input  s0, s1, gnt, out_valid, out_data, out_ch, err
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after last_ch, wrapping mod 4.
module rr_pick4
    import mux_seq_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last_ch,
    output logic            any,
    output logic [CH_W-1:0] ch
);

    logic [CH_W-1:0] base;
    logic [N_CH-1:0] rot;
    logic [CH_W-1:0] off;

    assign base = last_ch + CH_W'(1);
    assign rot  = N_CH'({req, req} >> base);
    assign any  = |req;

    // Lowest set bit of the rotated vector is the next channel after last_ch.
    always_comb begin
        off = '0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) off = CH_W'(i);
        end
    end

    assign ch = base + off;

endmodule

// File: rtl/mux4_rr_sequencer.sv
// Round-robin sequencer driving mux_4x1 selects and forwarding the sampled y on valid/ready.
module mux4_rr_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    mux4_rr_sequencer_if.master        bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_e          state,   state_n;
    logic [CH_W-1:0] sel,     sel_n;
    logic [N_CH-1:0] gnt,     gnt_n;
    logic            ovalid,  ovalid_n;
    beat_t           beat,    beat_n;
    logic            err,     err_n;
    logic [TMR_W-1:0] timer,  timer_n;
    logic [CH_W-1:0] last_ch, last_ch_n;

    logic            pick_any;
    logic [CH_W-1:0] pick_ch;

    rr_pick4 u_pick (
        .req     (bus.req),
        .last_ch (last_ch),
        .any     (pick_any),
        .ch      (pick_ch)
    );

    // State and output registers; last_ch resets to 3 so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            gnt     <= '0;
            ovalid  <= 1'b0;
            beat    <= '0;
            err     <= 1'b0;
            timer   <= '0;
            last_ch <= CH_W'(N_CH - 1);
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            gnt     <= gnt_n;
            ovalid  <= ovalid_n;
            beat    <= beat_n;
            err     <= err_n;
            timer   <= timer_n;
            last_ch <= last_ch_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        sel_n     = sel;
        gnt_n     = gnt;
        ovalid_n  = ovalid;
        beat_n    = beat;
        err_n     = 1'b0;
        timer_n   = timer;
        last_ch_n = last_ch;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    sel_n          = pick_ch;
                    gnt_n          = '0;
                    gnt_n[pick_ch] = 1'b1;
                    state_n        = SAMPLE;
                end
            end
            SAMPLE: begin
                beat_n.data = bus.mux_y;
                beat_n.ch   = sel;
                ovalid_n    = 1'b1;
                timer_n     = '0;
                state_n     = HOLD;
            end
            HOLD: begin
                // Accept and timeout retire the beat identically; only a drop flags err.
                if (bus.out_ready || (timer == TMR_W'(TIMEOUT - 1))) begin
                    ovalid_n  = 1'b0;
                    gnt_n     = '0;
                    last_ch_n = beat.ch;
                    err_n     = ~bus.out_ready;
                    state_n   = IDLE;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.s0        = sel[0];
    assign bus.s1        = sel[1];
    assign bus.gnt       = gnt;
    assign bus.out_valid = ovalid;
    assign bus.out_data  = beat.data;
    assign bus.out_ch    = beat.ch;
    assign bus.err       = err;

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// Bench for mux4_rr_sequencer with a behavioural mux_4x1 and a handshake scoreboard.
module tb_mux4_rr_sequencer;
    import mux_seq_pkg::*;

    logic clk;
    logic rst;
    logic [3:0] d;
    logic [3:0] d_t;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] ch;
        logic       data;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] d;
        logic [1:0] ch;
        logic       data;
    } vec_t;

    exp_t sb_q[$];

    mux4_rr_sequencer_if bus ();
    mux4_rr_sequencer_if bus_t ();

    mux4_rr_sequencer #(.TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    mux4_rr_sequencer #(.TIMEOUT(4)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t.master)
    );

    // mux_4x1 models
    assign bus.mux_y   = d[{bus.s1, bus.s0}];
    assign bus_t.mux_y = d_t[{bus_t.s1, bus_t.s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on every accepted beat.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_beat", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_ch", int'(bus.out_ch), int'(e.ch));
                chk("sb_data", int'(bus.out_data), int'(e.data));
            end
        end
    end

    task automatic run_beat(input logic [3:0] r, input logic [3:0] dv,
                            input logic [1:0] ch, input logic data);
        exp_t e;
        bus.req = r; d = dv; bus.out_ready = 1'b1;
        e.ch = ch; e.data = data;
        sb_q.push_back(e);
        tick();
        chk("sel", int'({bus.s1, bus.s0}), int'(ch));
        chk("gnt", int'(bus.gnt), int'(4'b0001 << ch));
        chk("valid_sample", int'(bus.out_valid), 0);
        tick();
        chk("valid_hold", int'(bus.out_valid), 1);
        chk("out_ch", int'(bus.out_ch), int'(ch));
        chk("out_data", int'(bus.out_data), int'(data));
        tick();
        chk("valid_idle", int'(bus.out_valid), 0);
        chk("gnt_idle", int'(bus.gnt), 0);
        chk("sel_kept", int'({bus.s1, bus.s0}), int'(ch));
        chk("err_none", int'(bus.err), 0);
    endtask

    vec_t vecs[9];

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;

        // rotation, single beat, then mixed priority patterns
        vecs[0] = '{4'hF,    4'b1001, 2'd0, 1'b1};
        vecs[1] = '{4'hF,    4'b1001, 2'd1, 1'b0};
        vecs[2] = '{4'hF,    4'b1001, 2'd2, 1'b0};
        vecs[3] = '{4'hF,    4'b1001, 2'd3, 1'b1};
        vecs[4] = '{4'hF,    4'b1001, 2'd0, 1'b1};
        vecs[5] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[6] = '{4'b0101, 4'b0001, 2'd0, 1'b1};
        vecs[7] = '{4'b1010, 4'b1000, 2'd1, 1'b0};
        vecs[8] = '{4'b0011, 4'b0011, 2'd0, 1'b1};

        rst = 1'b1;
        bus.req = 4'hF; bus.out_ready = 1'b0; d = 4'h0;
        bus_t.req = 4'h0; bus_t.out_ready = 1'b0; d_t = 4'h0;
        tick();
        tick();
        chk("rst_sel", int'({bus.s1, bus.s0}), 0);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_ch", int'(bus.out_ch), 0);
        chk("rst_err", int'(bus.err), 0);
        rst = 1'b0;

        foreach (vecs[i]) run_beat(vecs[i].req, vecs[i].d, vecs[i].ch, vecs[i].data);

        // Backpressure: five stalled cycles in HOLD, then accept.
        bus.req = 4'b0010; d = 4'b0010; bus.out_ready = 1'b0;
        tick();
        tick();
        chk("bp_valid_rise", int'(bus.out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_data", int'(bus.out_data), 1);
            chk("bp_sel", int'({bus.s1, bus.s0}), 1);
            chk("bp_err", int'(bus.err), 0);
        end
        e.ch = 2'd1; e.data = 1'b1;
        sb_q.push_back(e);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_accept", int'(bus.out_valid), 0);
        chk("bp_err_after", int'(bus.err), 0);

        // Reset while holding a ch2 beat: discarded, priority back to ch0.
        bus.req = 4'b0100; d = 4'b0000; bus.out_ready = 1'b0;
        tick();
        tick();
        chk("mr_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        tick();
        chk("mr_valid_clr", int'(bus.out_valid), 0);
        chk("mr_err", int'(bus.err), 0);
        chk("mr_gnt", int'(bus.gnt), 0);
        rst = 1'b0;
        run_beat(4'hF, 4'b0001, 2'd0, 1'b1);

        // Request withdrawn during SAMPLE: beat still delivered.
        e.ch = 2'd3; e.data = 1'b1;
        sb_q.push_back(e);
        bus.req = 4'b1000; d = 4'b1000; bus.out_ready = 1'b1;
        tick();
        bus.req = 4'b0000;
        tick();
        chk("wd_valid", int'(bus.out_valid), 1);
        chk("wd_ch", int'(bus.out_ch), 3);
        tick();
        chk("wd_idle", int'(bus.out_valid), 0);
        tick();
        chk("wd_no_regrant", int'(bus.gnt), 0);

        // Timeout on the TIMEOUT=4 instance.
        bus_t.req = 4'b0011; d_t = 4'b0001; bus_t.out_ready = 1'b0;
        tick();
        chk("to_sel0", int'({bus_t.s1, bus_t.s0}), 0);
        tick();
        chk("to_valid_rise", int'(bus_t.out_valid), 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("to_err", int'(bus_t.err), (k == 4) ? 1 : 0);
            chk("to_valid", int'(bus_t.out_valid), (k == 4) ? 0 : 1);
        end
        tick();
        chk("to_err_pulse", int'(bus_t.err), 0);
        chk("to_next_sel", int'({bus_t.s1, bus_t.s0}), 1);
        chk("to_next_gnt", int'(bus_t.gnt), 2);
        bus_t.out_ready = 1'b1;
        tick();
        tick();
        chk("to_next_done", int'(bus_t.out_valid), 0);
        chk("to_next_err", int'(bus_t.err), 0);
        bus_t.req = 4'b0000;

        tick();
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
